bcd_scan_display: RTL and testbench
===================================

Name: bcd_scan_display

Overview:
- Downstream consumer of the 8-bit binary-to-BCD converter.
- Accepts a packed 3-digit BCD value {hundreds[1:0], tens[3:0], ones[3:0]} through a valid/ready handshake.
- Drives one time-multiplexed 7-segment digit at a time, with a programmable refresh prescaler.
- A new value reaches the display only at a frame boundary, so no frame ever mixes two values.

Parameters:
SCAN_DIV, 50000, clk cycles per digit slot (>=2); benches use 4
DIV_W, 16, prescaler width; must satisfy 2**DIV_W >= SCAN_DIV

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
bcd_in  in  10  packed BCD: [9:8] hundreds, [7:4] tens, [3:0] ones
bcd_valid  in  1  bcd_in valid
bcd_ready  out  1  holding register free (= !pending), combinational from flop
seg  out  7  segment drive, active-high, seg[0]=a ... seg[6]=g, registered
an  out  3  one-hot digit enable, active-high, an[0]=ones, an[2]=hundreds, registered
frame_done  out  1  one-cycle pulse when digit slot 2 ends
digit_err  out  1  displayed value holds a tens/ones digit >9, registered

Behaviour:
- Reset (async, rst_n=0): prescaler=0, idx=0, disp_reg=0, hold_reg=0, pending=0, seg=7'h00, an=3'b000, frame_done=0, digit_err=0; bcd_ready=1.
- Handshake: transfer when bcd_valid && bcd_ready.
  - On transfer: hold_reg<=bcd_in, pending<=1.
  - bcd_ready=0 while pending; bcd_in is ignored while bcd_ready=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - tick = (prescaler==SCAN_DIV-1).
- Digit index:
  - On tick, idx advances 0->1->2->0.
  - The value 3 is unreachable.
- Frame boundary (tick && idx==2):
  - frame_done=1 the next cycle, for exactly one cycle.
  - If pending: disp_reg<=hold_reg, pending<=0, digit_err<=(tens>9 || ones>9) evaluated on hold_reg.
  - If a frame boundary coincides with bcd_valid while pending=1: the promotion happens, and the input is not accepted that cycle. bcd_ready rises the following cycle.
- Output register, loaded every cycle (1-cycle latency from idx/disp_reg):
  - an<=onehot(idx).
  - seg<=decode(selected digit).
  - The first cycle after reset release gives an=001, seg=7'h3F.
- Decode:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 10..15 -> dash 7'h40.
  - Hundreds is zero-extended to 4 bits, so hundreds=3 shows "3"; no range check against 255.
- Reset mid-frame: all state returns to reset values immediately; any pending value is discarded.
- Steady idx, no new data: output repeats the same digit pattern each frame.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined:
  - Hundreds digit is blanked (seg=7'h00, an still asserted) when hundreds==0.
  - Tens digit is blanked when hundreds==0 && tens==0.
  - Ones digit is never blanked.
- Undefined: all three digits are always decoded; no blanking logic is synthesised.

Decomposition:
- Shared package bcd_disp_pkg holds:
  - localparams for the segment patterns (SEG_0..SEG_9, SEG_DASH, SEG_BLANK);
  - digit index constants DIG_ONES=0, DIG_TENS=1, DIG_HUND=2;
  - a typedef for the packed 10-bit BCD word.
- One sub-module, seg7_decode: combinational 4-bit digit -> 7-bit pattern, instantiated once on the muxed digit.

Test Plan (SCAN_DIV=4):
- Reset, release, no input:
  - seg=3F every slot; an cycles 001,010,100 in 4-cycle slots.
  - frame_done pulses every 12 cycles.
  - bcd_ready=1.
- Load 10'b01_0010_0101 (125):
  - bcd_ready drops to 0 until the next frame boundary.
  - The following frame shows ones=6D, tens=5B, hundreds=06.
  - bcd_ready returns to 1 the cycle after promotion.
- Back-to-back loads 200 then 099 with bcd_valid held high:
  - The second is accepted only after 200 is promoted.
  - 099 appears exactly one frame later.
  - No mixed frame is ever displayed.
- Load tens=4'hC, ones=3:
  - Tens slot shows 40, ones slot shows 4F.
  - digit_err=1 from promotion until a valid value is promoted.
- Load 007:
  - With LEADING_ZERO_BLANK_EN: hundreds and tens slots seg=00, ones=07.
  - Without the macro: 3F, 3F, 07.
- Assert rst_n=0 mid-slot with pending=1:
  - seg/an/frame_done/digit_err clear immediately.
  - After release the display shows 000 and the pending value is lost.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD scanned display: segment patterns,
// digit-slot indices and the packed 3-digit BCD word.
package bcd_disp_pkg;

    // Active-high segment patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit slot indices; the scan visits them in this order
    localparam logic [1:0] DIG_ONES = 2'd0;
    localparam logic [1:0] DIG_TENS = 2'd1;
    localparam logic [1:0] DIG_HUND = 2'd2;

    // Packed BCD word as produced by the upstream binary-to-BCD converter
    typedef struct packed {
        logic [1:0] hund;
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_word_t;

    // True when either full-width digit holds a non-decimal code
    function automatic logic digit_invalid(input bcd_word_t w);
        return (w.tens > 4'd9) || (w.ones > 4'd9);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to 7-segment pattern decoder.
// Codes 10..15 render as a dash so a bad digit is visible on the display.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Lookup of the segment pattern for one digit
    always_comb begin
        // NOTE: every combinational output gets a value on every path
        // (here via the default arm), otherwise a latch is inferred.
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 3-digit 7-segment driver fed by a valid/ready BCD stream.
// Incoming values wait in a holding register and are promoted to the
// displayed register only at a frame boundary, so a frame never mixes values.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DIV_W    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] bcd_in,
    input  logic       bcd_valid,
    output logic       bcd_ready,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_done,
    output logic       digit_err
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] prescaler;
    logic [1:0]       idx;
    bcd_word_t        disp_reg;
    bcd_word_t        hold_reg;
    logic             pending;
    logic             tick;
    logic             frame_end;
    logic [3:0]       digit_mux;
    logic [6:0]       digit_seg;
    logic [6:0]       seg_next;

    assign tick      = (prescaler == DIV_LAST);
    assign frame_end = tick && (idx == DIG_HUND);
    assign bcd_ready = !pending;

    // Slot timing: prescaler divides clk, idx steps through the three digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= DIG_ONES;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                idx <= (idx == DIG_HUND) ? DIG_ONES : idx + 2'd1;
            end
        end
    end

    // Handshake capture and frame-boundary promotion to the displayed value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            disp_reg  <= '0;
            pending   <= 1'b0;
            digit_err <= 1'b0;
        end else if (frame_end && pending) begin
            disp_reg  <= hold_reg;
            pending   <= 1'b0;
            digit_err <= digit_invalid(hold_reg);
        end else if (bcd_valid && bcd_ready) begin
            hold_reg <= bcd_in;
            pending  <= 1'b1;
        end
    end

    // Select the digit for the current slot; hundreds is zero-extended
    always_comb begin
        case (idx)
            DIG_ONES: digit_mux = disp_reg.ones;
            DIG_TENS: digit_mux = disp_reg.tens;
            DIG_HUND: digit_mux = {2'b00, disp_reg.hund};
            default:  digit_mux = 4'd0;
        endcase
    end

    seg7_decode u_decode (
        .digit (digit_mux),
        .seg   (digit_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Blank leading zeros; the ones digit always shows
    always_comb begin
        seg_next = digit_seg;
        if ((idx == DIG_HUND) && (disp_reg.hund == 2'd0)) begin
            seg_next = SEG_BLANK;
        end
        if ((idx == DIG_TENS) && (disp_reg.hund == 2'd0) && (disp_reg.tens == 4'd0)) begin
            seg_next = SEG_BLANK;
        end
    end
`else
    assign seg_next = digit_seg;
`endif

    // Registered display drive and frame-end pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= SEG_BLANK;
            an         <= 3'b000;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            an         <= 3'(3'b001 << idx);
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with SCAN_DIV=4 (12-cycle frames).
// Expected segment patterns follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_bcd_scan_display;

    logic       clk;
    logic       rst_n;
    logic [9:0] bcd_in;
    logic       bcd_valid;
    logic       bcd_ready;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;
    logic       digit_err;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    bcd_scan_display #(.SCAN_DIV(4), .DIV_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .bcd_ready  (bcd_ready),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done),
        .digit_err  (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait for a frame_done sample; also report whether bcd_ready stayed low before it
    task automatic wait_frame_done(output bit got, output bit ready_low);
        got = 1'b0;
        ready_low = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (bcd_ready !== 1'b0) ready_low = 1'b0;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_wait: got no frame_done, required one within 40 cycles");
        end
    endtask

    // Present one value for a single cycle
    task automatic load(input logic [9:0] v);
        bcd_in = v;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    // Observe the 12 cycles after a frame_done sample; frame = {hund, tens, ones}.
    // shape_ok: an walks 001/010/100 in 4-cycle slots, seg stable per slot,
    // frame_done only on the last cycle. bcd_valid is dropped after cycle 0.
    task automatic capture_frame(output logic [20:0] frame, output bit shape_ok,
                                 output logic rdy_first);
        logic [2:0] exp_an;
        logic [6:0] cur;
        shape_ok = 1'b1;
        frame = '0;
        cur = '0;
        rdy_first = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rdy_first = bcd_ready;
                bcd_valid = 1'b0;
            end
            exp_an = 3'(1 << (i / 4));
            if (an !== exp_an) shape_ok = 1'b0;
            if (frame_done !== (i == 11)) shape_ok = 1'b0;
            if (i % 4 == 0) cur = seg;
            else if (seg !== cur) shape_ok = 1'b0;
            case (i / 4)
                0:       frame[6:0]   = cur;
                1:       frame[13:7]  = cur;
                default: frame[20:14] = cur;
            endcase
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bcd_valid = 1'b0;
        bcd_in = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({seg, an, frame_done, digit_err, bcd_ready} !== {7'h00, 3'b000, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state: got seg=%h an=%b fd=%b err=%b rdy=%b, required 00 000 0 0 1",
                     seg, an, frame_done, digit_err, bcd_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({an, seg, frame_done} !== {3'b001, 7'h3F, 1'b0}) begin
            n_bad++;
            $display("FAIL first_cycle: got an=%b seg=%h fd=%b, required 001 3f 0", an, seg, frame_done);
        end
    endtask

    task automatic test_idle();
        bit got, low, ok;
        logic [20:0] f;
        logic r;
        wait_frame_done(got, low);
        if (!got) return;
        n_cmp++;
        if (bcd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_ready: got %b, required 1", bcd_ready);
        end
        capture_frame(f, ok, r);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL idle_shape: got bad scan/pulse timing, required clean frame"); end
        n_cmp++;
        if (f !== {LZ, LZ, 7'h3F}) begin
            n_bad++;
            $display("FAIL idle_frame: got %h, required %h", f, {LZ, LZ, 7'h3F});
        end
    endtask

    task automatic test_load_125();
        bit got, low, ok;
        logic [20:0] f;
        logic r;
        load(10'b01_0010_0101);
        n_cmp++;
        if (bcd_ready !== 1'b0) begin n_bad++; $display("FAIL l125_ready_drop: got %b, required 0", bcd_ready); end
        wait_frame_done(got, low);
        if (!got) return;
        n_cmp++;
        if (!low) begin n_bad++; $display("FAIL l125_ready_held: got ready high before boundary, required low"); end
        n_cmp++;
        if ({bcd_ready, digit_err} !== 2'b10) begin
            n_bad++;
            $display("FAIL l125_after_promo: got rdy=%b err=%b, required 1 0", bcd_ready, digit_err);
        end
        capture_frame(f, ok, r);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL l125_shape: got bad scan/pulse timing, required clean frame"); end
        n_cmp++;
        if (f !== {7'h06, 7'h5B, 7'h6D}) begin
            n_bad++;
            $display("FAIL l125_frame: got %h, required %h", f, {7'h06, 7'h5B, 7'h6D});
        end
    endtask

    task automatic test_back_to_back();
        bit got, low, ok;
        logic [20:0] f;
        logic r;
        bcd_in = 10'b10_0000_0000;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_in = 10'b00_1001_1001;
        n_cmp++;
        if (bcd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_first_accept: got rdy=%b, required 0", bcd_ready); end
        wait_frame_done(got, low);
        if (!got) return;
        n_cmp++;
        if (!low) begin n_bad++; $display("FAIL b2b_ready_held: got ready high while pending, required low"); end
        n_cmp++;
        if (bcd_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_rise: got %b, required 1", bcd_ready); end
        capture_frame(f, ok, r);
        n_cmp++;
        if (r !== 1'b0) begin n_bad++; $display("FAIL b2b_second_accept: got rdy=%b, required 0", r); end
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_shape1: got bad scan/pulse timing, required clean frame"); end
        n_cmp++;
        if (f !== {7'h5B, 7'h3F, 7'h3F}) begin
            n_bad++;
            $display("FAIL b2b_frame200: got %h, required %h", f, {7'h5B, 7'h3F, 7'h3F});
        end
        capture_frame(f, ok, r);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL b2b_shape2: got bad scan/pulse timing, required clean frame"); end
        n_cmp++;
        if (f !== {LZ, 7'h6F, 7'h6F}) begin
            n_bad++;
            $display("FAIL b2b_frame099: got %h, required %h", f, {LZ, 7'h6F, 7'h6F});
        end
    endtask

    task automatic test_digits();
        bit got, low, ok;
        logic [20:0] f;
        logic r;
        load(10'b10_0110_1000);
        wait_frame_done(got, low);
        if (!got) return;
        capture_frame(f, ok, r);
        n_cmp++;
        if (f !== {7'h5B, 7'h7D, 7'h7F}) begin
            n_bad++;
            $display("FAIL dig_frame268: got %h, required %h", f, {7'h5B, 7'h7D, 7'h7F});
        end
        load(10'b00_0100_0001);
        wait_frame_done(got, low);
        if (!got) return;
        capture_frame(f, ok, r);
        n_cmp++;
        if (f !== {LZ, 7'h66, 7'h06}) begin
            n_bad++;
            $display("FAIL dig_frame041: got %h, required %h", f, {LZ, 7'h66, 7'h06});
        end
    endtask

    task automatic test_digit_err();
        bit got, low, ok;
        logic [20:0] f;
        logic r;
        load(10'b00_1100_0011);
        wait_frame_done(got, low);
        if (!got) return;
        n_cmp++;
        if (digit_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b, required 1", digit_err); end
        capture_frame(f, ok, r);
        n_cmp++;
        if (f !== {LZ, 7'h40, 7'h4F}) begin
            n_bad++;
            $display("FAIL err_frame: got %h, required %h", f, {LZ, 7'h40, 7'h4F});
        end
        load(10'b00_0000_0111);
        n_cmp++;
        if (digit_err !== 1'b1) begin n_bad++; $display("FAIL err_held: got %b, required 1", digit_err); end
        wait_frame_done(got, low);
        if (!got) return;
        n_cmp++;
        if (digit_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b, required 0", digit_err); end
        capture_frame(f, ok, r);
        n_cmp++;
        if (f !== {LZ, LZ, 7'h07}) begin
            n_bad++;
            $display("FAIL frame007: got %h, required %h", f, {LZ, LZ, 7'h07});
        end
    endtask

    task automatic test_reset_mid();
        bit got, low, ok;
        logic [20:0] f;
        logic r;
        load(10'b11_1111_0101);
        wait_frame_done(got, low);
        if (!got) return;
        capture_frame(f, ok, r);
        n_cmp++;
        if (f !== {7'h4F, 7'h40, 7'h6D}) begin
            n_bad++;
            $display("FAIL hund3_frame: got %h, required %h", f, {7'h4F, 7'h40, 7'h6D});
        end
        load(10'b11_0101_0101);
        n_cmp++;
        if ({bcd_ready, digit_err} !== 2'b01) begin
            n_bad++;
            $display("FAIL rmid_pre: got rdy=%b err=%b, required 0 1", bcd_ready, digit_err);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({seg, an, frame_done, digit_err, bcd_ready} !== {7'h00, 3'b000, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL rmid_clear: got seg=%h an=%b fd=%b err=%b rdy=%b, required 00 000 0 0 1",
                     seg, an, frame_done, digit_err, bcd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wait_frame_done(got, low);
        if (!got) return;
        capture_frame(f, ok, r);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL rmid_shape: got bad scan/pulse timing, required clean frame"); end
        n_cmp++;
        if (f !== {LZ, LZ, 7'h3F}) begin
            n_bad++;
            $display("FAIL rmid_frame: got %h, required %h", f, {LZ, LZ, 7'h3F});
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_load_125();
        test_back_to_back();
        test_digits();
        test_digit_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
